sdp_ram_be_pipe: RTL
====================

Name: sdp_ram_be_pipe

Overview:
Parametrised simple dual-port RAM: port A write-only, port B read-only, one clock. It is the successor to the existing simple dual-port RAM and adds:
- per-byte write enables
- selectable read latency (1 or 2) with a read-valid strobe
- defined read/write collision mode
- an optional post-reset zero-initialisation sequencer

It is used as the generic buffer RAM behind FIFOs and packet stores.

Parameters:
- DATA_W, 32, data width in bits; must be a multiple of BYTE_W (elaboration error otherwise).
- DEPTH, 1024, number of words; need not be a power of two.
- ADDR_W, $clog2(DEPTH), address width.
- BYTE_W, 8, bits per byte lane; NBE = DATA_W/BYTE_W.
- READ_LATENCY, 1, 1 or 2 clock edges from read request to data (other values: elaboration error).
- COLLISION_MODE, 0, 0 = read-first (old data), 1 = write-first (merged new data).
- INIT_ON_RESET, 1, 1 = zero the whole array after reset; 0 = no init.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- wena  in  1  port A write request
- addra  in  ADDR_W  port A address
- dina  in  DATA_W  port A write data
- bea  in  NBE  port A byte-lane enables; bit i covers dina[i*BYTE_W +: BYTE_W]
- renb  in  1  port B read request
- addrb  in  ADDR_W  port B address
- doutb  out  DATA_W  port B read data
- validb  out  1  doutb valid strobe, one cycle per accepted read
- init_busy  out  1  high while the init sequencer runs; no user access accepted

Behaviour:
- Reset (async assert, sync release):
  - doutb=0, validb=0, all read pipeline stages cleared.
  - FSM goes to INIT if INIT_ON_RESET=1, else READY.
  - init_busy=1 in INIT, including while rst is held.
  - Memory contents are not reset directly.
- FSM states: INIT, READY.
  - INIT: counter runs 0..DEPTH-1 and writes one zero word per cycle (all lanes).
  - After the edge that writes DEPTH-1: FSM -> READY and init_busy=0. INIT therefore lasts exactly DEPTH cycles after rst release.
  - READY: terminal state; left only via rst.
- During INIT:
  - wena and renb are ignored; no memory change from port A.
  - validb stays 0.
- Write (READY):
  - At the edge where wena=1, each lane i with bea[i]=1 gets mem[addra] lane i <= dina lane i.
  - Lanes with bea[i]=0 are unchanged. wena=1 with bea=0 is a no-op.
  - addra >= DEPTH: write dropped.
- Read (READY), accepted at edge k when renb=1:
  - READ_LATENCY=1: doutb/validb update at edge k.
  - READ_LATENCY=2: doutb/validb update at edge k+1, through an output register stage.
  - validb is high for exactly one cycle per accepted read.
  - doutb holds its last value when validb=0.
  - addrb >= DEPTH: returns 0 with validb=1.
  - Full throughput: one read per cycle; back-to-back reads give a continuous validb.
- Collision (wena=1, renb=1, addra==addrb, same edge):
  - COLLISION_MODE=0: doutb = contents before the write.
  - COLLISION_MODE=1: per lane, enabled lanes return dina and disabled lanes return old data.
  - The array is updated in both modes.
  - Write in an earlier cycle, read in a later cycle: always returns new data.
- Reset mid-operation:
  - In-flight reads are discarded and validb drops to 0 immediately.
  - INIT restarts from address 0.

Test Plan:
Default bench: DATA_W=32, DEPTH=1024, BYTE_W=8.

1. Init: hold rst 3 cycles, then release -> init_busy=1 for exactly 1024 cycles, then 0. Read addr 0x3FF -> doutb=0x00000000, validb=1 after 1 edge.
2. Basic write/read: write addr 0x001 with dina=0x00000055, bea=4'hF; next cycle renb, addrb=0x001 -> doutb=0x00000055. Data appears one edge later (READ_LATENCY=1) or two edges later (READ_LATENCY=2).
3. Byte enables: write 0xAABBCCDD to addr 0x010 with bea=4'hF, then 0x11223344 with bea=4'b0101 -> read addr 0x010 returns 0xAA22CC44.
4. Collision: mem[5]=0x12345678; same edge write 0xFFFFFFFF with bea=4'b0011 and read addr 5.
   - Mode 0 -> 0x12345678; mode 1 -> 0x1234FFFF.
   - Subsequent read of addr 5 -> 0x1234FFFF in both modes.
5. Reset during INIT/read:
   - During INIT, write 0xDEAD to addr 2 -> after INIT, read addr 2 returns 0.
   - Assert rst at INIT cycle 300 -> init_busy is 1024 cycles long after release.
   - Assert rst with a read in flight -> validb is 0 immediately.
6. Streaming: preload addr 0..7 with values 0x100+i; renb=1 for 8 consecutive cycles on addr 0..7 -> validb high 8 consecutive cycles, doutb=0x100..0x107 in order, no gaps.

Source files
------------

// File: rtl/sdp_ram_be_pipe_if.sv
// Port bundle for sdp_ram_be_pipe: write-only port A, read-only port B, init status.
interface sdp_ram_be_pipe_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned NBE    = 4
);
    logic              wena;
    logic [ADDR_W-1:0] addra;
    logic [DATA_W-1:0] dina;
    logic [NBE-1:0]    bea;
    logic              renb;
    logic [ADDR_W-1:0] addrb;
    logic [DATA_W-1:0] doutb;
    logic              validb;
    logic              init_busy;

    modport master (
        output wena, addra, dina, bea, renb, addrb,
        input  doutb, validb, init_busy
    );

    modport slave (
        input  wena, addra, dina, bea, renb, addrb,
        output doutb, validb, init_busy
    );
endinterface

// File: rtl/sdp_ram_be_pipe.sv
// Simple dual-port RAM with byte enables, 1/2-cycle read latency, selectable
// read/write collision behaviour and an optional post-reset zeroing sequencer.
module sdp_ram_be_pipe #(
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned DEPTH          = 1024,
    parameter int unsigned ADDR_W         = $clog2(DEPTH),
    parameter int unsigned BYTE_W         = 8,
    parameter int unsigned READ_LATENCY   = 1,
    parameter int unsigned COLLISION_MODE = 0,
    parameter int unsigned INIT_ON_RESET  = 1
) (
    input  logic               clk,
    input  logic               rst,
    sdp_ram_be_pipe_if.slave   bus
);
    localparam int unsigned NBE = DATA_W / BYTE_W;

    if ((DATA_W % BYTE_W) != 0) begin : g_bad_byte_w
        $error("sdp_ram_be_pipe: DATA_W must be a multiple of BYTE_W");
    end
    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
        $error("sdp_ram_be_pipe: READ_LATENCY must be 1 or 2");
    end
    if (COLLISION_MODE > 1 || INIT_ON_RESET > 1) begin : g_bad_mode
        $error("sdp_ram_be_pipe: COLLISION_MODE and INIT_ON_RESET must be 0 or 1");
    end

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    localparam state_t            RST_STATE = (INIT_ON_RESET != 0) ? ST_INIT : ST_READY;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    logic              mem_we_c;
    logic [ADDR_W-1:0] mem_addr_c;
    logic [DATA_W-1:0] mem_din_c;
    logic [NBE-1:0]    mem_be_c;
    logic              rd_en_c;
    logic [DATA_W-1:0] rd_data_c;
    logic              wr_ok_c;
    logic              rd_ok_c;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              s1_valid_q;
    logic [DATA_W-1:0] s1_data_q;
    logic              validb_q;
    logic [DATA_W-1:0] doutb_q;

    // Address range qualification; trivially true when DEPTH fills the address space
    if (DEPTH == (1 << ADDR_W)) begin : g_full_range
        assign wr_ok_c = 1'b1;
        assign rd_ok_c = 1'b1;
    end else begin : g_part_range
        localparam logic [ADDR_W:0] DEPTH_CMP = (ADDR_W + 1)'(DEPTH);
        assign wr_ok_c = ({1'b0, bus.addra} < DEPTH_CMP);
        assign rd_ok_c = ({1'b0, bus.addrb} < DEPTH_CMP);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RST_STATE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Sequencer: INIT owns the write port until the last word is zeroed
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mem_we_c   = 1'b0;
        mem_addr_c = bus.addra;
        mem_din_c  = bus.dina;
        mem_be_c   = bus.bea;
        rd_en_c    = 1'b0;
        case (state_q)
            ST_INIT: begin
                mem_we_c   = 1'b1;
                mem_addr_c = cnt_q;
                mem_din_c  = '0;
                mem_be_c   = '1;
                cnt_d      = cnt_q + ADDR_W'(1);
                if (cnt_q == LAST_ADDR) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                mem_we_c = bus.wena && wr_ok_c;
                rd_en_c  = bus.renb;
            end
            default: state_d = RST_STATE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            for (int i = 0; i < int'(NBE); i++) begin
                if (mem_be_c[i]) begin
                    mem[mem_addr_c][i*BYTE_W +: BYTE_W] <= mem_din_c[i*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    // Array read sees pre-write contents; write-first overlays enabled lanes of dina
    always_comb begin
        rd_data_c = '0;
        if (rd_ok_c) begin
            rd_data_c = mem[bus.addrb];
        end
        if (COLLISION_MODE == 1 && mem_we_c && bus.addra == bus.addrb) begin
            for (int i = 0; i < int'(NBE); i++) begin
                if (bus.bea[i]) begin
                    rd_data_c[i*BYTE_W +: BYTE_W] = bus.dina[i*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            validb_q   <= 1'b0;
            doutb_q    <= '0;
        end else begin
            s1_valid_q <= rd_en_c;
            if (rd_en_c) begin
                s1_data_q <= rd_data_c;
            end
            if (READ_LATENCY == 1) begin
                validb_q <= rd_en_c;
                if (rd_en_c) begin
                    doutb_q <= rd_data_c;
                end
            end else begin
                validb_q <= s1_valid_q;
                if (s1_valid_q) begin
                    doutb_q <= s1_data_q;
                end
            end
        end
    end

    assign bus.doutb     = doutb_q;
    assign bus.validb    = validb_q;
    assign bus.init_busy = (state_q == ST_INIT);

endmodule
